// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// UART receive engine for the AHB UART peripheral. Samples the serial line
// with the shared oversampled baud tick, deserialises LSB-first frames
// (start, DATA_BITS data, optional even parity, stop) and presents each byte
// with a single-cycle rx_done strobe plus framing/parity error flags.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   b_tick     in   baud tick, OVERSAMPLE pulses per bit period
//   rx         in   serial line (idle high), already synchronised to clk
//   d_out      out  last received data word (held until next rx_done)
//   rx_done    out  one-clk pulse when d_out / frame_err / parity_err update
//   frame_err  out  stop bit was sampled low on the last frame
//   parity_err out  parity mismatch on the last frame (0 when parity is off)
//
// Build option:
//   UART_RX_PARITY_EN  when defined, an even-parity bit follows the data bits
//                      and parity_err reports mismatches; when undefined the
//                      PARITY state is never entered and parity_err is tied 0.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned SB_TICKS   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err
);

    // Tick counter is log2(OVERSAMPLE) wide; widened only if SB_TICKS needs more.
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned SB_W = $clog2(SB_TICKS);
    localparam int unsigned SW   = (OS_W >= SB_W) ? ((OS_W > 0) ? OS_W : 1)
                                                  : SB_W;
    localparam int unsigned NW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [SW-1:0]          s_q, s_d;
    logic [NW-1:0]          n_q, n_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [DATA_BITS-1:0]   d_out_q, d_out_d;
    logic                   rx_done_q, rx_done_d;
    logic                   frame_err_q, frame_err_d;

`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   parity_err_q, parity_err_d;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        sh_d        = sh_q;
        d_out_d     = d_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif

        case (state_q)
            // Falling edge is taken on any clock, independent of b_tick.
            IDLE: begin
                if (!rx) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            // Re-check the line in the middle of the start bit to reject glitches.
            START: begin
                if (b_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            // Sample one full bit period after the previous mid-bit point.
            DATA: begin
                if (b_tick) begin
                    if (s_q == S_LAST) begin
                        s_d  = '0;
                        sh_d = {rx, sh_q[DATA_BITS-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (b_tick) begin
                    if (s_q == S_LAST) begin
                        par_d   = rx;
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif

            // A bad stop bit still delivers the word, flagged as a framing error.
            STOP: begin
                if (b_tick) begin
                    if (s_q == S_STOP) begin
                        rx_done_d   = 1'b1;
                        d_out_d     = sh_q;
                        frame_err_d = ~rx;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ^{sh_q, par_q};
`endif
                        state_d     = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            sh_q        <= '0;
            d_out_q     <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            sh_q        <= sh_d;
            d_out_q     <= d_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign d_out     = d_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx: b_tick held high so one bit lasts 16 clks.
// A negedge monitor records every rx_done event (cycle, data, flags); the
// linear stimulus sequence then compares those records against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam int unsigned LAT        = 169;
    localparam int unsigned FRAME_CLKS = 176;
`else
    localparam int unsigned LAT        = 153;
    localparam int unsigned FRAME_CLKS = 160;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       b_tick;
    logic       rx;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned start_cyc;

    typedef struct {
        int unsigned t;
        logic [7:0]  d;
        logic        fe;
        logic        pe;
    } ev_t;

    ev_t evq[$];

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .b_tick     (b_tick),
        .rx         (rx),
        .d_out      (d_out),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1)
            evq.push_back('{cyc, d_out, frame_err, parity_err});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait k rising edges, then step just past the edge.
    task automatic hold(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_raw(input logic [7:0] data, input logic stop, input logic par);
        rx = 1'b0;
        start_cyc = cyc + 1;
        hold(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            hold(16);
        end
        rx = par;
        hold(16);
        rx = stop;
        hold(16);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] data, input logic stop);
        send_raw(data, stop, ^data);
    endtask
`else
    task automatic send(input logic [7:0] data, input logic stop);
        rx = 1'b0;
        start_cyc = cyc + 1;
        hold(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            hold(16);
        end
        rx = stop;
        hold(16);
        rx = 1'b1;
    endtask
`endif

    initial begin
        int unsigned s0;

        reset  = 1'b1;
        b_tick = 1'b1;
        rx     = 1'b1;
        hold(3);
        reset = 1'b0;

        // Reset state
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_d_out", 32'(d_out), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        hold(5);

        // 1: single good frame 0xA5, latency from first clk seeing rx=0
        evq.delete();
        send(8'hA5, 1'b1);
        s0 = start_cyc;
        hold(20);
        check("t1_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) begin
            check("t1_latency", evq[0].t - s0 + 1, LAT);
            check("t1_data", 32'(evq[0].d), 32'hA5);
            check("t1_frame_err", 32'(evq[0].fe), 32'd0);
            check("t1_parity_err", 32'(evq[0].pe), 32'd0);
        end
        check("t1_hold_d_out", 32'(d_out), 32'hA5);
        check("t1_rx_done_low", 32'(rx_done), 32'd0);

        // 2: back-to-back 0x00 then 0xFF, no idle between frames
        evq.delete();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        hold(20);
        check("t2_count", 32'(evq.size()), 32'd2);
        if (evq.size() == 2) begin
            check("t2_data0", 32'(evq[0].d), 32'h00);
            check("t2_data1", 32'(evq[1].d), 32'hFF);
            check("t2_fe0", 32'(evq[0].fe), 32'd0);
            check("t2_fe1", 32'(evq[1].fe), 32'd0);
            check("t2_spacing", evq[1].t - evq[0].t, FRAME_CLKS);
        end

        // 3: short start glitch is rejected, then 0x12 received
        evq.delete();
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(30);
        check("t3_glitch_count", 32'(evq.size()), 32'd0);
        check("t3_d_out_kept", 32'(d_out), 32'hFF);
        send(8'h12, 1'b1);
        hold(20);
        check("t3_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) begin
            check("t3_data", 32'(evq[0].d), 32'h12);
            check("t3_frame_err", 32'(evq[0].fe), 32'd0);
        end

        // 4: stop bit low -> framing error, next good frame clears it
        evq.delete();
        send(8'h3C, 1'b0);
        hold(40);
        check("t4_bad_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) begin
            check("t4_bad_data", 32'(evq[0].d), 32'h3C);
            check("t4_bad_fe", 32'(evq[0].fe), 32'd1);
        end
        check("t4_fe_held", 32'(frame_err), 32'd1);
        evq.delete();
        send(8'h3C, 1'b1);
        hold(20);
        check("t4_good_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) begin
            check("t4_good_data", 32'(evq[0].d), 32'h3C);
            check("t4_good_fe", 32'(evq[0].fe), 32'd0);
        end

        // 5: reset during data bit 3 of 0x81 aborts it; 0x5A follows
        evq.delete();
        rx = 1'b0; hold(16);
        rx = 1'b1; hold(16);
        rx = 1'b0; hold(16);
        rx = 1'b0; hold(16);
        rx = 1'b0; hold(8);
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        rx = 1'b1;
        check("t5_rst_d_out", 32'(d_out), 32'd0);
        check("t5_rst_frame_err", 32'(frame_err), 32'd0);
        hold(40);
        check("t5_abort_count", 32'(evq.size()), 32'd0);
        send(8'h5A, 1'b1);
        hold(20);
        check("t5_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) begin
            check("t5_data", 32'(evq[0].d), 32'h5A);
            check("t5_frame_err", 32'(evq[0].fe), 32'd0);
        end

`ifdef UART_RX_PARITY_EN
        // 6: 0x07 has odd weight, so parity bit 0 is wrong and 1 is right
        evq.delete();
        send_raw(8'h07, 1'b1, 1'b0);
        s0 = start_cyc;
        hold(20);
        check("t6a_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) begin
            check("t6a_data", 32'(evq[0].d), 32'h07);
            check("t6a_parity_err", 32'(evq[0].pe), 32'd1);
            check("t6a_latency", evq[0].t - s0 + 1, 32'd169);
        end
        evq.delete();
        send_raw(8'h07, 1'b1, 1'b1);
        s0 = start_cyc;
        hold(20);
        check("t6b_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) begin
            check("t6b_parity_err", 32'(evq[0].pe), 32'd0);
            check("t6b_latency", evq[0].t - s0 + 1, 32'd169);
        end
`else
        check("t6_parity_tied", 32'(parity_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
